blackjack_score_display: RTL and testbench

- Registered, parametrised successor to the combinational hex/message output stage of the blackjack design.
- Accepts a snapshot of N hand scores plus a game-message code through a valid/ready handshake.
- Converts each score to two decimal digits with a sequential shift-add-3 (double-dabble) converter, then commits all 7-segment outputs atomically.
- Adds hidden-hand masking (dealer hole card), leading-zero blanking and an optional blinking message field; sits between the game FSM and the board HEX pins.

---
 rtl/blackjack_score_display_if.sv | 37 +++
 rtl/blackjack_score_display.sv | 232 +++++++++++++++++++++++
 tb/tb_blackjack_score_display.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/blackjack_score_display_if.sv
// blackjack_score_display_if
//   Update channel between the game FSM (master) and the score display
//   stage (slave).
//   Handshake: an update moves on a rising clock edge where upd_valid and
//   upd_ready are both high. The master holds upd_valid and the payload
//   (hand_scores, hand_hide, msg_code, msg_blink) stable until that edge.
//   upd_ready is high only while the display is idle. upd_done pulses for
//   one cycle once the new segment outputs are visible.
//   Signals:
//     upd_valid, hand_scores, hand_hide, msg_code, msg_blink : master -> slave
//     upd_ready, upd_done, hand_seg, msg_seg, dbg_state      : slave -> master
//     dbg_state : current FSM state (0 IDLE, 1 SHIFT, 2 STORE, 3 COMMIT)
interface blackjack_score_display_if #(
    parameter int NUM_HANDS = 2,
    parameter int SCORE_W   = 5
);
    logic                           upd_valid;
    logic                           upd_ready;
    logic [NUM_HANDS*SCORE_W-1:0]   hand_scores;
    logic [NUM_HANDS-1:0]           hand_hide;
    logic [2:0]                     msg_code;
    logic                           msg_blink;
    logic                           upd_done;
    logic [NUM_HANDS*14-1:0]        hand_seg;
    logic [27:0]                    msg_seg;
    logic [1:0]                     dbg_state;

    modport master (
        output upd_valid, hand_scores, hand_hide, msg_code, msg_blink,
        input  upd_ready, upd_done, hand_seg, msg_seg, dbg_state
    );

    modport slave (
        input  upd_valid, hand_scores, hand_hide, msg_code, msg_blink,
        output upd_ready, upd_done, hand_seg, msg_seg, dbg_state
    );
endinterface

// File: rtl/blackjack_score_display.sv
// blackjack_score_display
//   Registered 7-segment output stage for the blackjack game. Accepts a
//   snapshot of NUM_HANDS scores plus a message code, converts each score
//   to two decimal digits with a sequential double-dabble converter (one
//   shift per cycle), then commits all segment outputs in one cycle.
//   Supports per-hand hiding ("--"), tens-digit blanking and, when the
//   DISPLAY_BLINK_EN macro is defined, a blinking message field.
//   Ports:
//     clk   : system clock
//     reset : synchronous, active-high
//     bus   : blackjack_score_display_if.slave (update channel + segments)
//   Segments are active-low, bit0 = a ... bit6 = g.
//   Latency: outputs change on edge NUM_HANDS*(SCORE_W+1)+1 after acceptance.
module blackjack_score_display #(
    parameter int NUM_HANDS = 2,
    parameter int SCORE_W   = 5,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                         clk,
    input  logic                         reset,
    blackjack_score_display_if.slave     bus
);

    if (NUM_HANDS < 1 || NUM_HANDS > 4) begin : gNumHandsCheck
        $error("NUM_HANDS must be 1..4");
    end
    if (SCORE_W < 4 || SCORE_W > 6) begin : gScoreWCheck
        $error("SCORE_W must be 4..6");
    end
    if (BLINK_DIV < 1) begin : gBlinkDivCheck
        $error("BLINK_DIV must be at least 1");
    end

    localparam int          DDW      = SCORE_W + 8;
    localparam logic [1:0]  LAST_IDX = 2'(NUM_HANDS - 1);
    localparam logic [2:0]  LAST_BIT = 3'(SCORE_W - 1);
    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [6:0]  SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, STORE = 2'd2, COMMIT = 2'd3} state_t;

    state_t state, nextState;

    logic [NUM_HANDS*SCORE_W-1:0] scoresReg;
    logic [NUM_HANDS-1:0]         hideReg;
    logic [2:0]                   codeReg;
    logic [DDW-1:0]               ddReg;
    logic [2:0]                   bitCnt;
    logic [1:0]                   idx;
    logic [NUM_HANDS*14-1:0]      shadowSeg;
    logic [NUM_HANDS*14-1:0]      handSegReg;
    logic [27:0]                  msgSegReg;
    logic                         doneReg;
    logic                         accept;

    // Character codes shared with sevenSegmentDecoder: 0-9 digits,
    // 10-35 letters A-Z, 62 dash, 63 blank.
    function automatic logic [6:0] segOf(input logic [5:0] c);
        logic [6:0] s;
        case (c)
            6'd0:  s = 7'h40;  6'd1:  s = 7'h79;  6'd2:  s = 7'h24;
            6'd3:  s = 7'h30;  6'd4:  s = 7'h19;  6'd5:  s = 7'h12;
            6'd6:  s = 7'h02;  6'd7:  s = 7'h78;  6'd8:  s = 7'h00;
            6'd9:  s = 7'h10;
            6'd10: s = 7'h08;  // A
            6'd11: s = 7'h03;  // b
            6'd14: s = 7'h06;  // E
            6'd17: s = 7'h09;  // H
            6'd18: s = 7'h79;  // I
            6'd19: s = 7'h61;  // J
            6'd20: s = 7'h0A;  // K
            6'd21: s = 7'h47;  // L
            6'd23: s = 7'h2B;  // n
            6'd24: s = 7'h40;  // O
            6'd25: s = 7'h0C;  // P
            6'd27: s = 7'h2F;  // r
            6'd28: s = 7'h12;  // S
            6'd29: s = 7'h07;  // t
            6'd32: s = 7'h41;  // W (drawn as U)
            6'd34: s = 7'h11;  // Y
            6'd62: s = SEG_DASH;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [27:0] msgSegOf(input logic [2:0] code);
        logic [23:0] chars;  // four 6-bit character codes, leftmost first
        case (code)
            3'd1:    chars = {6'd28, 6'd29, 6'd27, 6'd29};  // STRT
            3'd2:    chars = {6'd25, 6'd21, 6'd10, 6'd34};  // PLAY
            3'd3:    chars = {6'd17, 6'd18, 6'd29, 6'd63};  // HIT
            3'd4:    chars = {6'd11, 6'd21, 6'd19, 6'd20};  // BLJK
            3'd5:    chars = {6'd32, 6'd18, 6'd23, 6'd63};  // WIN
            3'd6:    chars = {6'd21, 6'd24, 6'd28, 6'd14};  // LOSE
            3'd7:    chars = {6'd29, 6'd18, 6'd14, 6'd63};  // TIE
            default: chars = {4{6'd63}};
        endcase
        return {segOf(chars[23:18]), segOf(chars[17:12]), segOf(chars[11:6]), segOf(chars[5:0])};
    endfunction

    // One double-dabble step: add 3 to any BCD nibble >= 5, then shift left.
    function automatic logic [DDW-1:0] ddStep(input logic [DDW-1:0] v);
        logic [DDW-1:0] t;
        t = v;
        if (t[SCORE_W+3:SCORE_W] >= 4'd5)   t[SCORE_W+3:SCORE_W]   = t[SCORE_W+3:SCORE_W] + 4'd3;
        if (t[SCORE_W+7:SCORE_W+4] >= 4'd5) t[SCORE_W+7:SCORE_W+4] = t[SCORE_W+7:SCORE_W+4] + 4'd3;
        return t << 1;
    endfunction

    // Loop-based select keeps every part-select statically in range.
    function automatic logic [SCORE_W-1:0] scoreAt(input logic [NUM_HANDS*SCORE_W-1:0] s,
                                                   input logic [1:0] sel);
        logic [SCORE_W-1:0] r;
        r = '0;
        for (int h = 0; h < NUM_HANDS; h++)
            if (2'(h) == sel) r = s[h*SCORE_W +: SCORE_W];
        return r;
    endfunction

    assign accept = bus.upd_valid && (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:   if (bus.upd_valid) nextState = SHIFT;
            SHIFT:  if (bitCnt == LAST_BIT) nextState = STORE;
            STORE:  nextState = (idx == LAST_IDX) ? COMMIT : SHIFT;
            COMMIT: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scoresReg  <= '0;
            hideReg    <= '0;
            codeReg    <= '0;
            ddReg      <= '0;
            bitCnt     <= '0;
            idx        <= '0;
            shadowSeg  <= {(NUM_HANDS*2){SEG_BLANK}};
            handSegReg <= {(NUM_HANDS*2){SEG_BLANK}};
            msgSegReg  <= {4{SEG_BLANK}};
            doneReg    <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        scoresReg <= bus.hand_scores;
                        hideReg   <= bus.hand_hide;
                        codeReg   <= bus.msg_code;
                        ddReg     <= {8'd0, bus.hand_scores[SCORE_W-1:0]};
                        bitCnt    <= '0;
                        idx       <= '0;
                    end
                end
                SHIFT: begin
                    ddReg  <= ddStep(ddReg);
                    bitCnt <= (bitCnt == LAST_BIT) ? 3'd0 : bitCnt + 3'd1;
                end
                STORE: begin
                    // Hidden hands are converted anyway so latency never varies.
                    for (int h = 0; h < NUM_HANDS; h++) begin
                        if (2'(h) == idx) begin
                            if (hideReg[h])
                                shadowSeg[h*14 +: 14] <= {SEG_DASH, SEG_DASH};
                            else
                                shadowSeg[h*14 +: 14] <= {
                                    (ddReg[SCORE_W+7:SCORE_W+4] == 4'd0) ? SEG_BLANK
                                        : segOf({2'b00, ddReg[SCORE_W+7:SCORE_W+4]}),
                                    segOf({2'b00, ddReg[SCORE_W+3:SCORE_W]})};
                        end
                    end
                    if (idx != LAST_IDX) begin
                        idx   <= idx + 2'd1;
                        ddReg <= {8'd0, scoreAt(scoresReg, idx + 2'd1)};
                    end
                end
                COMMIT: begin
                    handSegReg <= shadowSeg;
                    msgSegReg  <= msgSegOf(codeReg);
                    doneReg    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef DISPLAY_BLINK_EN
    logic [31:0] blinkCnt;
    logic        blinkPhase;  // 1 = message shown
    logic        blinkReq;    // blink request that belongs to the capture in flight
    logic        dispBlink;   // blink request of the message currently shown

    always_ff @(posedge clk) begin
        if (reset) begin
            blinkCnt   <= '0;
            blinkPhase <= 1'b1;
            blinkReq   <= 1'b0;
            dispBlink  <= 1'b0;
        end else begin
            if (blinkCnt == 32'(BLINK_DIV - 1)) begin
                blinkCnt   <= '0;
                blinkPhase <= ~blinkPhase;
            end else begin
                blinkCnt <= blinkCnt + 32'd1;
            end
            if (accept)           blinkReq  <= bus.msg_blink;
            if (state == COMMIT)  dispBlink <= blinkReq;
        end
    end

    assign bus.msg_seg = (dispBlink && !blinkPhase) ? {4{SEG_BLANK}} : msgSegReg;
`else
    logic unusedBlink;
    assign unusedBlink = bus.msg_blink;
    assign bus.msg_seg = msgSegReg;
`endif

    assign bus.upd_ready = (state == IDLE);
    assign bus.upd_done  = doneReg;
    assign bus.hand_seg  = handSegReg;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_blackjack_score_display.sv
module tb_blackjack_score_display;

    localparam int NH = 2;
    localparam int SW = 5;
    localparam int LAT = NH * (SW + 1) + 1;  // 13

    localparam logic [6:0] BL = 7'h7F, DA = 7'h3F;
    localparam logic [6:0] D0 = 7'h40, D1 = 7'h79, D2 = 7'h24, D3 = 7'h30, D5 = 7'h12;
    localparam logic [6:0] D7 = 7'h78, D9 = 7'h10;
    localparam logic [6:0] CW = 7'h41, CI = 7'h79, CN = 7'h2B, CH = 7'h09, CT = 7'h07;
    localparam logic [6:0] CS = 7'h12, CR = 7'h2F, CL = 7'h47, CO = 7'h40, CE = 7'h06;
    localparam logic [6:0] CB = 7'h03, CJ = 7'h61, CK = 7'h0A;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;

    blackjack_score_display_if #(.NUM_HANDS(NH), .SCORE_W(SW)) bus ();

    blackjack_score_display #(
        .NUM_HANDS(NH),
        .SCORE_W(SW)
`ifdef DISPLAY_BLINK_EN
        , .BLINK_DIV(4)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Present a request at a falling edge; it is accepted on the next rising edge.
    // Returns at the falling edge after acceptance.
    task automatic send(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] hide,
                        input logic [2:0] code, input logic blink, input logic hold);
        @(negedge clk);
        bus.hand_scores = {s1, s0};
        bus.hand_hide   = hide;
        bus.msg_code    = code;
        bus.msg_blink   = blink;
        bus.upd_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.upd_valid = 1'b0;
    endtask

    // Counts rising edges until upd_done is seen; pre holds hand_seg just before.
    task automatic wait_done(output int lat, output logic [27:0] pre, output logic timeout);
        lat = 0;
        timeout = 1'b1;
        pre = bus.hand_seg;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.upd_done) begin
                timeout = 1'b0;
                break;
            end
            pre = bus.hand_seg;
        end
    endtask

    task automatic test_reset;
        bus.upd_valid = 1'b0; bus.hand_scores = '0; bus.hand_hide = '0;
        bus.msg_code = '0; bus.msg_blink = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.hand_seg !== {4{BL}}) begin
            failures++; $display("FAIL reset_hand_seg got=%h exp=%h", bus.hand_seg, {4{BL}});
        end
        checks++;
        if (bus.msg_seg !== {4{BL}}) begin
            failures++; $display("FAIL reset_msg_seg got=%h exp=%h", bus.msg_seg, {4{BL}});
        end
        checks++;
        if (bus.upd_ready !== 1'b1 || bus.upd_done !== 1'b0) begin
            failures++; $display("FAIL reset_handshake ready=%b done=%b exp ready=1 done=0",
                                 bus.upd_ready, bus.upd_done);
        end
    endtask

    task automatic test_basic;
        int lat; logic [27:0] pre; logic to;
        send(5'd21, 5'd7, 2'b00, 3'd5, 1'b0, 1'b0);
        wait_done(lat, pre, to);
        checks++;
        if (to || lat != LAT) begin
            failures++; $display("FAIL basic_latency got=%0d timeout=%b exp=%0d", lat, to, LAT);
        end
        checks++;
        if (pre !== {4{BL}}) begin
            failures++; $display("FAIL basic_hold_before_commit got=%h exp=%h", pre, {4{BL}});
        end
        checks++;
        if (bus.hand_seg !== {BL, D7, D2, D1}) begin
            failures++; $display("FAIL basic_hand_seg got=%h exp=%h", bus.hand_seg, {BL, D7, D2, D1});
        end
        checks++;
        if (bus.msg_seg !== {CW, CI, CN, BL}) begin
            failures++; $display("FAIL basic_msg_win got=%h exp=%h", bus.msg_seg, {CW, CI, CN, BL});
        end
        checks++;
        if (bus.upd_ready !== 1'b1) begin
            failures++; $display("FAIL basic_ready_with_done got=%b exp=1", bus.upd_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.upd_done !== 1'b0) begin
            failures++; $display("FAIL basic_done_one_cycle got=%b exp=0", bus.upd_done);
        end
    endtask

    task automatic test_hide;
        int lat; logic [27:0] pre; logic to;
        send(5'd0, 5'd17, 2'b10, 3'd3, 1'b0, 1'b0);
        wait_done(lat, pre, to);
        checks++;
        if (to || lat != LAT) begin
            failures++; $display("FAIL hide_latency got=%0d timeout=%b exp=%0d", lat, to, LAT);
        end
        checks++;
        if (bus.hand_seg !== {DA, DA, BL, D0}) begin
            failures++; $display("FAIL hide_hand_seg got=%h exp=%h", bus.hand_seg, {DA, DA, BL, D0});
        end
        checks++;
        if (bus.msg_seg !== {CH, CI, CT, BL}) begin
            failures++; $display("FAIL hide_msg_hit got=%h exp=%h", bus.msg_seg, {CH, CI, CT, BL});
        end
        // Max 5-bit score and hiding the player instead
        send(5'd31, 5'd10, 2'b01, 3'd7, 1'b0, 1'b0);
        wait_done(lat, pre, to);
        checks++;
        if (to || bus.hand_seg !== {D1, D0, DA, DA}) begin
            failures++; $display("FAIL hide_player got=%h exp=%h", bus.hand_seg, {D1, D0, DA, DA});
        end
        send(5'd31, 5'd10, 2'b00, 3'd7, 1'b0, 1'b0);
        wait_done(lat, pre, to);
        checks++;
        if (to || bus.hand_seg !== {D1, D0, D3, D1}) begin
            failures++; $display("FAIL max_score got=%h exp=%h", bus.hand_seg, {D1, D0, D3, D1});
        end
        checks++;
        if (bus.msg_seg !== {CT, CI, CE, BL}) begin
            failures++; $display("FAIL msg_tie got=%h exp=%h", bus.msg_seg, {CT, CI, CE, BL});
        end
    endtask

    task automatic test_back_to_back;
        int lat; int lowCnt; logic seen; logic [27:0] pre; logic to;
        lowCnt = 0; seen = 1'b0;
        send(5'd9, 5'd12, 2'b00, 3'd1, 1'b0, 1'b1);
        // New payload while busy; must not disturb the first result.
        bus.hand_scores = {5'd5, 5'd20};
        bus.msg_code    = 3'd6;
        for (int i = 0; i < 60; i++) begin
            if (bus.upd_done) begin seen = 1'b1; break; end
            if (!bus.upd_ready) lowCnt++;
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (!seen || lowCnt != LAT) begin
            failures++; $display("FAIL b2b_ready_low got=%0d seen=%b exp=%0d", lowCnt, seen, LAT);
        end
        checks++;
        if (bus.hand_seg !== {D1, D2, BL, D9} || bus.msg_seg !== {CS, CT, CR, CT}) begin
            failures++; $display("FAIL b2b_first_result got=%h/%h exp=%h/%h", bus.hand_seg, bus.msg_seg,
                                 {D1, D2, BL, D9}, {CS, CT, CR, CT});
        end
        @(posedge clk);
        @(negedge clk);
        bus.upd_valid = 1'b0;
        checks++;
        if (bus.upd_ready !== 1'b0 || bus.upd_done !== 1'b0) begin
            failures++; $display("FAIL b2b_second_accept ready=%b done=%b exp ready=0 done=0",
                                 bus.upd_ready, bus.upd_done);
        end
        wait_done(lat, pre, to);
        checks++;
        if (to || lat != LAT) begin
            failures++; $display("FAIL b2b_second_latency got=%0d timeout=%b exp=%0d", lat, to, LAT);
        end
        checks++;
        if (bus.hand_seg !== {BL, D5, D2, D0} || bus.msg_seg !== {CL, CO, CS, CE}) begin
            failures++; $display("FAIL b2b_second_result got=%h/%h exp=%h/%h", bus.hand_seg, bus.msg_seg,
                                 {BL, D5, D2, D0}, {CL, CO, CS, CE});
        end
    endtask

    task automatic test_reset_mid;
        int doneCnt;
        doneCnt = 0;
        send(5'd15, 5'd3, 2'b00, 3'd2, 1'b0, 1'b0);
        repeat (4) @(posedge clk);   // edges 2..5 (edge 1 already passed during send)
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);              // edge 6
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.hand_seg !== {4{BL}} || bus.msg_seg !== {4{BL}}) begin
            failures++; $display("FAIL rst_mid_blank got=%h/%h exp=all 7f", bus.hand_seg, bus.msg_seg);
        end
        checks++;
        if (bus.upd_ready !== 1'b1 || bus.upd_done !== 1'b0) begin
            failures++; $display("FAIL rst_mid_handshake ready=%b done=%b exp ready=1 done=0",
                                 bus.upd_ready, bus.upd_done);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.upd_done) doneCnt++;
        end
        checks++;
        if (doneCnt != 0 || bus.upd_ready !== 1'b1) begin
            failures++; $display("FAIL rst_mid_no_done got=%0d ready=%b exp=0 ready=1", doneCnt, bus.upd_ready);
        end
    endtask

    task automatic test_blink;
        int lat; logic [27:0] pre; logic to;
        logic [27:0] samp[16];
        logic [27:0] msgExp;
        int bad;
        msgExp = {CB, CL, CJ, CK};
        bad = 0;
        send(5'd21, 5'd20, 2'b00, 3'd4, 1'b1, 1'b0);
        wait_done(lat, pre, to);
        checks++;
        if (to || bus.hand_seg !== {D2, D0, D2, D1}) begin
            failures++; $display("FAIL blink_hand_seg got=%h exp=%h", bus.hand_seg, {D2, D0, D2, D1});
        end
        for (int i = 0; i < 16; i++) begin
            samp[i] = bus.msg_seg;
            @(negedge clk);
        end
`ifdef DISPLAY_BLINK_EN
        for (int i = 0; i < 16; i++)
            if (samp[i] !== msgExp && samp[i] !== {4{BL}}) bad++;
        for (int i = 0; i < 12; i++)
            if (samp[i] === samp[i+4]) bad++;
        for (int i = 0; i < 15; i++)
            if (samp[i] !== samp[i+1] && samp[i+1] === samp[(i+5) % 16] && i < 11) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL blink_alternate bad_samples=%0d exp=0", bad);
        end
`else
        for (int i = 0; i < 16; i++)
            if (samp[i] !== msgExp) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL blink_steady bad_samples=%0d first=%h exp=%h", bad, samp[0], msgExp);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_basic;
        test_hide;
        test_back_to_back;
        test_reset_mid;
        test_blink;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
